// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control FSM.
// Covers the state enum, the opcodes it decodes and the datapath select encodings.
package mc_ctrl_pkg;

    localparam int OPW = 6;
    localparam int STW = 4;

    typedef enum logic [STW-1:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADDR = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWR   = 4'd5,
        S_MEMWB   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ADDIEX  = 4'd11,
        S_ADDIWB  = 4'd12,
        S_ILLEGAL = 4'd13
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_word_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_ctrl_word_decode.sv
// Combinational control-word decode: state (plus mem_ready in FETCH) to datapath controls.
// Everything defaults to zero so a state only lists the controls it asserts.
module ctrl_word_decode
    import mc_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic       i_mem_ready,
    output ctrl_word_t o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                // IR and PC only capture once the instruction word is actually valid
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = SRCB_IMM_SH2;
            end
            S_MEMADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_B;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_B;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                o_ctrl.reg_write = 1'b1;
            end
            S_ILLEGAL: begin
                o_ctrl.illegal_op = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS CPU: state register and next-state logic.
// Control outputs come from ctrl_word_decode so they follow the state register directly.
module multicycle_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           PCWrite,
    output logic           PCWriteCond,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           MemtoReg,
    output logic           RegDst,
    output logic           RegWrite,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ALUOp,
    output logic [1:0]     PCSource,
    output logic           illegal_op,
    output logic [STW-1:0] state_dbg
);

    state_t     r_state;
    state_t     w_next;
    logic       r_is_load;
    ctrl_word_t w_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_is_load <= 1'b0;
        end else begin
            r_state <= w_next;
            // Remember lw vs sw so MEMADDR never has to look at the opcode again
            if (r_state == S_DECODE) begin
                r_is_load <= (opcode == OP_LW);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = S_FETCH;
            S_FETCH:   if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADDR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDIEX;
                    default:      w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADDR: w_next = r_is_load ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) w_next = S_MEMWB;
            S_MEMWR:   if (mem_ready) w_next = S_FETCH;
            S_EXEC:    w_next = S_RWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB, S_ILLEGAL:
                       w_next = S_FETCH;
            default:   w_next = S_IDLE;
        endcase
    end

    ctrl_word_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign PCWrite     = w_ctrl.pc_write;
    assign PCWriteCond = w_ctrl.pc_write_cond;
    assign IorD        = w_ctrl.iord;
    assign MemRead     = w_ctrl.mem_read;
    assign MemWrite    = w_ctrl.mem_write;
    assign IRWrite     = w_ctrl.ir_write;
    assign MemtoReg    = w_ctrl.mem_to_reg;
    assign RegDst      = w_ctrl.reg_dst;
    assign RegWrite    = w_ctrl.reg_write;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign ALUOp       = w_ctrl.alu_op;
    assign PCSource    = w_ctrl.pc_source;
    assign illegal_op  = w_ctrl.illegal_op;
    assign state_dbg   = STW'(r_state);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: an instruction-level model expands each instruction
// into its expected per-cycle (mem_ready, state, control word) sequence.
module tb_multicycle_ctrl_fsm;
    import mc_ctrl_pkg::*;

    typedef struct {
        logic        mr;
        logic [3:0]  st;
        logic [16:0] cw;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state_dbg;

    int    checks = 0;
    int    errors = 0;
    int    step_no = 0;
    string cur_tag = "reset";
    step_t exp_q[$];

    multicycle_ctrl_fsm #(.OPW(6), .STW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .illegal_op  (illegal_op),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    wire [16:0] obs_cw = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                          MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                          PCSource, illegal_op};

    function automatic logic [16:0] cw(input logic pcw, input logic pcwc, input logic iord,
                                       input logic mrd, input logic mwr, input logic irw,
                                       input logic m2r, input logic rdst, input logic rw,
                                       input logic srca, input logic [1:0] srcb,
                                       input logic [1:0] aop, input logic [1:0] pcs,
                                       input logic ill);
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs, ill};
    endfunction

    task automatic push(input logic mr, input logic [3:0] st, input logic [16:0] c);
        step_t s;
        s.mr = mr;
        s.st = st;
        s.cw = c;
        exp_q.push_back(s);
    endtask

    function automatic logic dc();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into cycles: fw/mw are memory wait cycles in fetch / data access
    task automatic model_instr(input logic [5:0] op, input int fw, input int mw);
        for (int k = 0; k < fw; k++)
            push(1'b0, 4'd1, cw(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0));
        push(1'b1, 4'd1, cw(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0));
        push(dc(), 4'd2, cw(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0));
        case (op)
            6'b100011: begin
                push(dc(), 4'd3, cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
                for (int k = 0; k < mw; k++)
                    push(1'b0, 4'd4, cw(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0));
                push(1'b1, 4'd4, cw(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0));
                push(dc(), 4'd6, cw(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0));
            end
            6'b101011: begin
                push(dc(), 4'd3, cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
                for (int k = 0; k < mw; k++)
                    push(1'b0, 4'd5, cw(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0));
                push(1'b1, 4'd5, cw(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0));
            end
            6'b000000: begin
                push(dc(), 4'd7, cw(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0));
                push(dc(), 4'd8, cw(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0));
            end
            6'b000100:
                push(dc(), 4'd9, cw(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0));
            6'b000010:
                push(dc(), 4'd10, cw(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0));
            6'b001000: begin
                push(dc(), 4'd11, cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
                push(dc(), 4'd12, cw(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0));
            end
            default:
                push(dc(), 4'd13, cw(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1));
        endcase
    endtask

    task automatic check_now(input logic [3:0] st, input logic [16:0] c);
        checks++;
        assert (state_dbg === st) else begin
            errors++;
            $error("FAIL %s state step %0d observed %0d expected %0d", cur_tag, step_no, state_dbg, st);
        end
        checks++;
        assert (obs_cw === c) else begin
            errors++;
            $error("FAIL %s ctrl step %0d observed %b expected %b", cur_tag, step_no, obs_cw, c);
        end
    endtask

    // Run n expected cycles (all when n < 0): drive mem_ready after the edge, check mid-cycle
    task automatic exec(input int n);
        step_t s;
        int done = 0;
        while (exp_q.size() > 0 && (n < 0 || done < n)) begin
            s = exp_q.pop_front();
            @(posedge clk);
            #1 mem_ready = s.mr;
            @(negedge clk);
            step_no++;
            check_now(s.st, s.cw);
            done++;
        end
    endtask

    task automatic run(input string tag, input logic [5:0] op, input int fw, input int mw);
        cur_tag = tag;
        step_no = 0;
        opcode = op;
        model_instr(op, fw, mw);
        exec(-1);
    endtask

    initial begin
        logic [5:0] ops[7];
        logic [5:0] op;
        ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000; ops[3] = 6'b000100;
        ops[4] = 6'b000010; ops[5] = 6'b001000; ops[6] = 6'b111111;

        repeat (2) @(negedge clk);
        check_now(4'd0, 17'd0);
        rst_n = 1'b1;
        #1 check_now(4'd0, 17'd0);

        run("lw",         6'b100011, 0, 0);
        run("fetch_wait", 6'b000000, 3, 0);
        run("sw_wait",    6'b101011, 0, 2);
        run("beq",        6'b000100, 0, 0);
        run("j",          6'b000010, 0, 0);
        run("rtype",      6'b000000, 0, 0);
        run("addi",       6'b001000, 0, 0);
        run("illegal",    6'b111111, 0, 0);
        run("lw_wait",    6'b100011, 1, 3);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
            else op = ops[$urandom_range(0, 6)];
            run("random", op, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Abort a load while it waits in MEMRD; outputs must drop without a clock edge
        cur_tag = "reset_memrd";
        step_no = 0;
        opcode = 6'b100011;
        model_instr(6'b100011, 0, 5);
        exec(4);
        #2 rst_n = 1'b0;
        #1 check_now(4'd0, 17'd0);
        exp_q.delete();
        @(negedge clk);
        check_now(4'd0, 17'd0);
        rst_n = 1'b1;

        run("after_reset", 6'b001000, 0, 0);
        run("after_reset_sw", 6'b101011, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
